// File: rtl/acc_err_monitor.sv
// Accuracy monitor for the approximate multiplier: recomputes a*b and
// accumulates sample count, error count, ED sum (saturating) and max ED.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             1-cycle run start, latches num_samples (N)
//   num_samples       samples in the run, 0 allowed
//   in_valid/in_ready sample handshake, ready only in RUN
//   a, b, prod_approx operands and approximate product
//   busy, done        RUN|DRAIN, DONE level
//   sample_cnt        samples accumulated
//   err_cnt           samples with nonzero ED
//   sum_ed, sat       saturating ED sum, sticky clamp flag
//   max_ed            largest ED seen
module acc_err_monitor #(
  parameter int DW    = 8,
  parameter int SUM_W = 32,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [2*DW-1:0]  prod_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*DW-1:0]  max_ed,
  output logic             sat
);

  localparam int PW  = 2 * DW;
  localparam int SW1 = SUM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [PW-1:0]    exact_q, exact_d;
  logic [PW-1:0]    appr_q, appr_d;
  logic             v1_q, v1_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic             last;
  logic [PW-1:0]    ed;
  logic [SUM_W:0]   sum_ext;

  assign accept = in_valid && (state_q == S_RUN);
  assign last   = accept && ((acc_q + CNT_W'(1)) == n_q);

  assign ed = (exact_q >= appr_q) ? (exact_q - appr_q)
                                  : (appr_q - exact_q);

  // One extra bit catches the carry that signals a clamp.
  assign sum_ext = {1'b0, sum_q} + SW1'(ed);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    ecnt_d  = ecnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    sat_d   = sat_q;
    exact_d = exact_q;
    appr_d  = appr_q;
    v1_d    = accept;

    // Stage 1: capture exact and approximate products.
    if (accept) begin
      exact_d = PW'(a) * PW'(b);
      appr_d  = prod_approx;
      acc_d   = acc_q + CNT_W'(1);
    end

    // Stage 2: fold ED into the statistics.
    if (v1_q) begin
      scnt_d = scnt_q + CNT_W'(1);
      if (ed != '0) begin
        ecnt_d = ecnt_q + CNT_W'(1);
      end
      if (ed > max_q) begin
        max_d = ed;
      end
      if (sum_ext[SUM_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[SUM_W-1:0];
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d    = num_samples;
          acc_d  = '0;
          scnt_d = '0;
          ecnt_d = '0;
          sum_d  = '0;
          max_d  = '0;
          sat_d  = 1'b0;
          if (num_samples == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!v1_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      scnt_q  <= '0;
      ecnt_q  <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      sat_q   <= 1'b0;
      exact_q <= '0;
      appr_q  <= '0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      ecnt_q  <= ecnt_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      exact_q <= exact_d;
      appr_q  <= appr_d;
      v1_q    <= v1_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = scnt_q;
  assign err_cnt    = ecnt_q;
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_acc_err_monitor.sv
// Bench for acc_err_monitor: directed runs, expected run totals
// queued at stimulus time and compared when done rises.
module tb_acc_err_monitor;

  typedef struct {
    logic [19:0] sc;
    logic [19:0] ec;
    logic [31:0] sum;
    logic [15:0] mx;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [19:0] num = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] p = '0;
  logic        sel = 1'b0;

  logic        in_ready, busy, done, sat;
  logic [19:0] sample_cnt, err_cnt;
  logic [31:0] sum_ed;
  logic [15:0] max_ed;

  logic        in_ready2, busy2, done2, sat2;
  logic [19:0] sample_cnt2, err_cnt2;
  logic [15:0] sum_ed2;
  logic [15:0] max_ed2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic done_prev = 1'b0;
  logic done2_prev = 1'b0;

  always #5 clk = ~clk;

  acc_err_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b),
    .prod_approx(p), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .sat(sat)
  );

  acc_err_monitor #(.SUM_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .num_samples(num), .in_valid(in_valid),
    .in_ready(in_ready2), .a(a), .b(b),
    .prod_approx(p), .busy(busy2), .done(done2),
    .sample_cnt(sample_cnt2), .err_cnt(err_cnt2),
    .sum_ed(sum_ed2), .max_ed(max_ed2), .sat(sat2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic push1(input int sc, input int ec, input int sm,
                       input int mx, input int st);
    exp_t e;
    e.sc = 20'(sc); e.ec = 20'(ec); e.sum = 32'(sm);
    e.mx = 16'(mx); e.sat = st[0];
    q1.push_back(e);
  endtask

  // Monitors: on each rising done, pop and compare run totals.
  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      if (q1.size() == 0) begin
        chk("mon_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("mon_sample_cnt", 32'(sample_cnt), 32'(e.sc));
        chk("mon_err_cnt", 32'(err_cnt), 32'(e.ec));
        chk("mon_sum_ed", sum_ed, e.sum);
        chk("mon_max_ed", 32'(max_ed), 32'(e.mx));
        chk("mon_sat", 32'(sat), 32'(e.sat));
      end
    end
    done_prev <= done;
  end

  always @(negedge clk) begin
    if (rst_n && done2 && !done2_prev) begin
      if (q2.size() == 0) begin
        chk("mon16_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("mon16_sample_cnt", 32'(sample_cnt2), 32'(e.sc));
        chk("mon16_err_cnt", 32'(err_cnt2), 32'(e.ec));
        chk("mon16_sum_ed", 32'(sum_ed2), e.sum);
        chk("mon16_max_ed", 32'(max_ed2), 32'(e.mx));
        chk("mon16_sat", 32'(sat2), 32'(e.sat));
      end
    end
    done2_prev <= done2;
  end

  // Caller is at a negedge; returns at the negedge after the accept.
  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [15:0] vp);
    int t;
    t = 0;
    a = va; b = vb; p = vp; in_valid = 1'b1;
    while (!(sel ? in_ready2 : in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic kick(input int n);
    num = 20'(n);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(sel ? done2 : done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int t;
    idle(2);
    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_sum_ed", sum_ed, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // T1: back-to-back, check latency
    kick(4);
    chk("t1_busy", 32'(busy), 32'd1);
    push1(4, 2, 29, 25, 0);
    send(8'd3, 8'd5, 16'd15);
    send(8'd255, 8'd255, 16'd65000);
    send(8'd16, 8'd16, 16'd260);
    send(8'd0, 8'd7, 16'd0);
    chk("t1_ready_after_last", 32'(in_ready), 32'd0);
    chk("t1_done_e0", 32'(done), 32'd0);
    idle(1);
    chk("t1_done_e1", 32'(done), 32'd0);
    chk("t1_cnt_e1", 32'(sample_cnt), 32'd4);
    idle(1);
    chk("t1_done_e2", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // T6: start in DONE clears; start in RUN ignored
    kick(3);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_cleared_cnt", 32'(sample_cnt), 32'd0);
    chk("t6_cleared_sum", sum_ed, 32'd0);
    chk("t6_cleared_max", 32'(max_ed), 32'd0);
    push1(3, 2, 12, 10, 0);
    send(8'd2, 8'd2, 16'd4);
    kick(1);
    chk("t6_run_start_cnt", 32'(sample_cnt), 32'd1);
    chk("t6_run_start_busy", 32'(busy), 32'd1);
    send(8'd10, 8'd10, 16'd90);
    send(8'd1, 8'd1, 16'd3);
    wait_done();

    // T2: gaps plus extra valid samples after the last
    kick(4);
    push1(4, 2, 29, 25, 0);
    send(8'd3, 8'd5, 16'd15);
    idle(2);
    send(8'd255, 8'd255, 16'd65000);
    idle(1);
    send(8'd16, 8'd16, 16'd260);
    idle(3);
    send(8'd0, 8'd7, 16'd0);
    a = 8'd255; b = 8'd255; p = 16'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done();

    // T5: reset mid-run
    kick(5);
    send(8'd3, 8'd3, 16'd8);
    send(8'd4, 8'd4, 16'd16);
    idle(1);
    chk("t5_pre_rst_cnt", 32'(sample_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cnt", 32'(sample_cnt), 32'd0);
    chk("t5_rst_err", 32'(err_cnt), 32'd0);
    chk("t5_rst_sum", sum_ed, 32'd0);
    chk("t5_rst_max", 32'(max_ed), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("t5_idle_done", 32'(done), 32'd0);

    // T3: N=0
    push1(0, 0, 0, 0, 0);
    kick(0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end

    // T5 follow-up: N=1 run from DONE
    kick(1);
    push1(1, 0, 0, 0, 0);
    send(8'd4, 8'd4, 16'd16);
    wait_done();
    idle(1);

    // T4: 16-bit sum saturates
    sel = 1'b1;
    e.sc = 20'd2; e.ec = 20'd2; e.sum = 32'd65535;
    e.mx = 16'd65535; e.sat = 1'b1;
    q2.push_back(e);
    kick(2);
    send(8'd0, 8'd0, 16'd65535);
    idle(1);
    chk("t4_sat_after_one", 32'(sat2), 32'd0);
    chk("t4_sum_after_one", 32'(sum_ed2), 32'd65535);
    send(8'd0, 8'd0, 16'd65535);
    wait_done();
    idle(2);

    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("leftover_expected", 32'(q1.size() + q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
